alu_sequencer: RTL
==================

Name: alu_sequencer

Overview:
- Multi-cycle control unit for the ALU datapath of the AVR-subset core.
- Fetches 16-bit instructions from program memory into an instruction register, which drives decode_unit.
- Consumes decode_unit results (opcode_type, opcode_group, opcode_rd, opcode_rr) to sequence register read, ALU execute and register/SREG writeback.
- Maintains the PC, an instruction-retired counter and an illegal-instruction trap.

Parameters:
- INSTR_WIDTH, 16, instruction width.
- R_ADDR_WIDTH, 5, register-file address width.
- PC_WIDTH, 10, program counter width (word addresses).
- CNT_WIDTH, 16, retired-instruction counter width.

Ports:
- clk  input  1  core clock, all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- halt  input  1  stop issuing fetches while high
- imem_req  output  1  fetch request to program memory
- imem_valid  input  1  imem_rdata valid this cycle
- imem_rdata  input  INSTR_WIDTH  fetched instruction
- pc  output  PC_WIDTH  address of next fetch
- instr  output  INSTR_WIDTH  instruction register; drives decode_unit.instruction
- opcode_type  input  `OPCODE_COUNT  from decode_unit
- opcode_group  input  `GROUP_COUNT  from decode_unit
- opcode_rd  input  R_ADDR_WIDTH  from decode_unit
- opcode_rr  input  R_ADDR_WIDTH  from decode_unit
- rf_rd_addr  output  R_ADDR_WIDTH  register-file read port A / destination
- rf_rr_addr  output  R_ADDR_WIDTH  register-file read port B
- alu_en  output  1  ALU operands/operation valid
- rf_wr_en  output  1  write ALU result to rf_rd_addr
- sreg_wr_en  output  1  update status register
- illegal  output  1  sticky trap flag
- retired  output  CNT_WIDTH  completed-instruction count

Behaviour:
- States: FETCH, DECODE, EXEC, WB, TRAP. Reset state is FETCH.
- Reset values: pc=0, instr=0, rf_rd_addr=0, rf_rr_addr=0, retired=0, illegal=0. imem_req, alu_en, rf_wr_en and sreg_wr_en are all 0.
- Control outputs are Moore-decoded from the state register:
  - imem_req = (state==FETCH) && !halt
  - alu_en = (state==EXEC)
  - rf_wr_en = sreg_wr_en = (state==WB)
  - illegal = (state==TRAP)
- FETCH:
  - If halt is high: imem_req=0, stay in FETCH, imem_valid ignored.
  - Otherwise wait with imem_req=1 until imem_valid=1.
  - On the imem_valid=1 cycle: instr<=imem_rdata, pc<=pc+1 (wraps 2^PC_WIDTH-1 -> 0), go to DECODE.
- DECODE: decode_unit is combinational on instr; this block samples its outputs at the end of the cycle.
  - opcode_type==`TYPE_UNKNOWN -> TRAP.
  - opcode_type==`TYPE_NOP -> retired+=1, go to FETCH.
  - opcode_group[`GROUP_ALU]==1 -> rf_rd_addr<=opcode_rd, rf_rr_addr<=opcode_rr, go to EXEC.
  - Any other decoded type -> TRAP.
- EXEC: alu_en=1 for exactly one cycle. Addresses are held. Go to WB.
- WB: rf_wr_en=1 and sreg_wr_en=1 for exactly one cycle, with rf_rd_addr unchanged. retired+=1, go to FETCH.
- ALU_ONE_OP instructions (e.g. NEG) follow the same path. rf_rr_addr takes whatever decode supplies; the ALU ignores it.
- TRAP: absorbing state. No fetch, no writes. pc and retired are frozen. Only rst_n exits it.
- Latency with zero-wait memory: ALU instruction 4 cycles issue-to-issue; NOP 2 cycles.
- retired wraps modulo 2^CNT_WIDTH.
- imem_valid while not in FETCH, or while halt is high in FETCH, is ignored; no instr update.
- halt affects only FETCH. An in-flight instruction completes through WB first.
- rst_n assertion at any point returns all state to reset values immediately (asynchronously). rf_wr_en/sreg_wr_en drop in the same instant, so no partial writeback. The abandoned instruction is not counted.
- No X on any output after reset. rf addresses hold their last value outside EXEC/WB.

Test Plan:
- Reset, zero-wait memory, imem_rdata=0x0C12 (ADD r1,r2) -> DECODE at cycle 2; alu_en=1 at cycle 3 with rf_rd_addr=1, rf_rr_addr=2; rf_wr_en=sreg_wr_en=1 at cycle 4; pc=1, retired=1.
- Sequence 0x0000, 0x0000, 0x1C34 (ADC r3,r4) -> NOPs take 2 cycles each and raise no enables; ADC writes rf_rd_addr=3; retired=3, pc=3.
- Fetch 0x9411 (NEG r1) -> alu_en then rf_wr_en with rf_rd_addr=1.
- Fetch 0xFFFF -> illegal=1 from the cycle after DECODE; imem_req stays 0 and pc stays frozen for 20 cycles; rst_n pulse clears illegal and pc=0.
- imem_valid held low 3 cycles in FETCH -> imem_req stays 1 and pc is unchanged. Raise halt during EXEC -> WB still completes, then imem_req=0 until halt drops.
- Preload pc=1023 via 1023 NOPs, then one more fetch -> pc wraps to 0. Assert rst_n low mid-EXEC -> no rf_wr_en pulse, retired unchanged at reset value 0.

Source files
------------

// File: rtl/alu_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/WB control unit for the AVR-subset ALU datapath.
// Owns the PC, instruction register, register-file addresses, retired counter and illegal trap.
`ifndef OPCODE_COUNT
`define OPCODE_COUNT 8
`endif
`ifndef GROUP_COUNT
`define GROUP_COUNT 4
`endif
`ifndef TYPE_UNKNOWN
`define TYPE_UNKNOWN 0
`endif
`ifndef TYPE_NOP
`define TYPE_NOP 1
`endif
`ifndef GROUP_ALU
`define GROUP_ALU 0
`endif

module alu_sequencer #(
  parameter int INSTR_WIDTH  = 16,
  parameter int R_ADDR_WIDTH = 5,
  parameter int PC_WIDTH     = 10,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     halt,
  output logic                     imem_req,
  input  logic                     imem_valid,
  input  logic [INSTR_WIDTH-1:0]   imem_rdata,
  output logic [PC_WIDTH-1:0]      pc,
  output logic [INSTR_WIDTH-1:0]   instr,
  input  logic [`OPCODE_COUNT-1:0] opcode_type,
  input  logic [`GROUP_COUNT-1:0]  opcode_group,
  input  logic [R_ADDR_WIDTH-1:0]  opcode_rd,
  input  logic [R_ADDR_WIDTH-1:0]  opcode_rr,
  output logic [R_ADDR_WIDTH-1:0]  rf_rd_addr,
  output logic [R_ADDR_WIDTH-1:0]  rf_rr_addr,
  output logic                     alu_en,
  output logic                     rf_wr_en,
  output logic                     sreg_wr_en,
  output logic                     illegal,
  output logic [CNT_WIDTH-1:0]     retired
);

  localparam logic [`OPCODE_COUNT-1:0] T_UNKNOWN = `OPCODE_COUNT'(`TYPE_UNKNOWN);
  localparam logic [`OPCODE_COUNT-1:0] T_NOP     = `OPCODE_COUNT'(`TYPE_NOP);

  typedef enum logic [2:0] {FETCH, DECODE, EXEC, WB, TRAP} state_t;

  state_t state, state_nxt;

  logic is_unknown, is_nop, is_alu;
  logic fetch_fire, dec_alu, retire;
  logic unused_group;

  assign is_unknown = (opcode_type == T_UNKNOWN);
  assign is_nop     = (opcode_type == T_NOP);
  assign is_alu     = opcode_group[`GROUP_ALU];
  // Only the ALU group bit steers sequencing; the rest of the group vector is don't-care.
  assign unused_group = ^opcode_group;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= FETCH;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      FETCH:   if (!halt && imem_valid) state_nxt = DECODE;
      DECODE: begin
        if (is_unknown)  state_nxt = TRAP;
        else if (is_nop) state_nxt = FETCH;
        else if (is_alu) state_nxt = EXEC;
        else             state_nxt = TRAP;
      end
      EXEC:    state_nxt = WB;
      WB:      state_nxt = FETCH;
      TRAP:    state_nxt = TRAP;
      default: state_nxt = FETCH;
    endcase
  end

  // Gating with rst_n keeps the request low while reset is held, even though state is FETCH.
  assign imem_req   = rst_n && (state == FETCH) && !halt;
  assign alu_en     = (state == EXEC);
  assign rf_wr_en   = (state == WB);
  assign sreg_wr_en = (state == WB);
  assign illegal    = (state == TRAP);

  assign fetch_fire = (state == FETCH) && !halt && imem_valid;
  assign dec_alu    = (state == DECODE) && !is_unknown && !is_nop && is_alu;
  assign retire     = ((state == DECODE) && !is_unknown && is_nop) || (state == WB);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc         <= '0;
      instr      <= '0;
      rf_rd_addr <= '0;
      rf_rr_addr <= '0;
      retired    <= '0;
    end else begin
      if (fetch_fire) begin
        instr <= imem_rdata;
        pc    <= pc + PC_WIDTH'(1);
      end
      if (dec_alu) begin
        rf_rd_addr <= opcode_rd;
        rf_rr_addr <= opcode_rr;
      end
      if (retire) retired <= retired + CNT_WIDTH'(1);
    end
  end

endmodule
